// File: rtl/iso_main_steering_n.sv
// Main-stream lane steering: buffers pixel words in a byte accumulator and
// deals bytes round-robin over 1..MAX_LANES active lanes, with end-of-line
// zero-padded flush, per-lane pad mask and an underflow pulse.
// Ports: clk, rst_n (sync, active-low), td_lane_count, sched_steering_en,
//   sched_eol, in_data/in_vld/in_rdy (input handshake), out_data, out_vld,
//   out_pad_mask, underflow (registered), occupancy (byte count).
// Option: define ISO_STEER_UFLOW_CNT_EN to add the uflow_cnt[15:0] output,
//   a saturating underflow counter cleared by reset and on lane-count latch.
module iso_main_steering_n #(
  parameter int MAX_LANES   = 4,
  parameter int PIXEL_BYTES = 6,
  localparam int ACC_BYTES  = PIXEL_BYTES + MAX_LANES,
  localparam int OW         = $clog2(ACC_BYTES + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [1:0]               td_lane_count,
  input  logic                     sched_steering_en,
  input  logic                     sched_eol,
  input  logic [PIXEL_BYTES*8-1:0] in_data,
  input  logic                     in_vld,
  output logic                     in_rdy,
  output logic [MAX_LANES*8-1:0]   out_data,
  output logic                     out_vld,
  output logic [MAX_LANES-1:0]     out_pad_mask,
  output logic                     underflow,
  output logic [OW-1:0]            occupancy
`ifdef ISO_STEER_UFLOW_CNT_EN
  ,
  output logic [15:0]              uflow_cnt
`endif
);

  localparam logic [OW-1:0] RDY_MAX = OW'(ACC_BYTES - PIXEL_BYTES);
  localparam logic [OW-1:0] PB_W    = OW'(PIXEL_BYTES);

  logic [7:0]           acc   [ACC_BYTES];
  logic [7:0]           acc_n [ACC_BYTES];
  logic [OW-1:0]        occ;
  logic [OW-1:0]        occ_n;
  logic [OW-1:0]        n_lanes;
  logic [OW-1:0]        n_dec;
  logic [OW-1:0]        taken;
  logic [OW-1:0]        remain;
  logic                 normal;
  logic                 emit;
  logic                 accept;
  logic                 latch;
  logic                 uf_now;
  logic [MAX_LANES*8-1:0] lane_d;
  logic [MAX_LANES-1:0]   lane_m;

  assign occupancy = occ;

  // Requested lane count, clamped to what this instance was built for.
  always_comb begin
    int req;
    req = 1;
    unique case (td_lane_count)
      2'd0: req = 1;
      2'd1: req = 2;
      2'd2: req = 4;
      2'd3: req = 8;
    endcase
    if (req > MAX_LANES) req = MAX_LANES;
    n_dec = OW'(req);
  end

  // Emit/accept decision. Space freed by this cycle's emit is visible
  // to in_rdy in the same cycle, which keeps the stream bubble-free.
  always_comb begin
    normal = (occ >= n_lanes);
    emit   = sched_steering_en &&
             (normal || (sched_eol && occ != '0));
    uf_now = sched_steering_en && !emit;
    taken  = '0;
    if (emit) taken = normal ? n_lanes : occ;
    remain = occ - taken;
    in_rdy = !rst_n || (remain <= RDY_MAX);
    accept = in_vld && in_rdy;
    occ_n  = remain + (accept ? PB_W : '0);
    latch  = (occ == '0) && !sched_steering_en;
  end

  // Next accumulator: survivors shift down to index 0, new word
  // lands directly behind them.
  always_comb begin
    for (int i = 0; i < ACC_BYTES; i++) begin
      int src;
      int dst;
      src      = i + int'(taken);
      dst      = i - int'(remain);
      acc_n[i] = 8'h00;
      if (src < int'(occ)) begin
        acc_n[i] = acc[src];
      end else if (accept && dst >= 0 && dst < PIXEL_BYTES) begin
        acc_n[i] = in_data[8*dst +: 8];
      end
    end
  end

  // Lane fan-out; a flush pads lanes beyond the remaining bytes.
  always_comb begin
    lane_d = '0;
    lane_m = '0;
    for (int k = 0; k < MAX_LANES; k++) begin
      if (emit && OW'(k) < n_lanes) begin
        if (OW'(k) < occ) lane_d[8*k +: 8] = acc[k];
        else              lane_m[k]        = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ          <= '0;
      n_lanes      <= OW'(1);
      out_data     <= '0;
      out_vld      <= 1'b0;
      out_pad_mask <= '0;
      underflow    <= 1'b0;
      for (int i = 0; i < ACC_BYTES; i++) acc[i] <= 8'h00;
    end else begin
      occ          <= occ_n;
      out_data     <= lane_d;
      out_vld      <= emit;
      out_pad_mask <= lane_m;
      underflow    <= uf_now;
      for (int i = 0; i < ACC_BYTES; i++) acc[i] <= acc_n[i];
      if (latch) n_lanes <= n_dec;
    end
  end

`ifdef ISO_STEER_UFLOW_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      uflow_cnt <= '0;
    end else if (latch) begin
      uflow_cnt <= '0;
    end else if (uf_now && uflow_cnt != 16'hFFFF) begin
      uflow_cnt <= uflow_cnt + 16'd1;
    end
  end
`endif

endmodule
